axi_memory_slave_burst: RTL
===========================

Name: axi_memory_slave_burst

Overview:
AXI4 burst responder with an internal word-addressed memory. It is the slave end of the channel driven by AXI_memory_master_burst. It accepts FIXED and INCR write and read bursts of 1–256 beats. Write and read channels run in independent state machines. It is the synthesizable replacement for the behavioural memory model in the master's bench.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width (multiple of 8)
MEM_DEPTH, 128, memory words (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
awaddr  in  ADDR_WIDTH  write burst start byte address
awlen  in  8  beats-1
awsize  in  3  log2 bytes/beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
awvalid/awready  in/out  1  AW handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  master's last-beat flag
wvalid/wready  in/out  1  W handshake
bresp  out  2  00 OKAY, 10 SLVERR
bvalid/bready  out/in  1  B handshake
araddr/arlen/arsize/arburst  in  ADDR_WIDTH/8/3/2  read burst descriptor
arvalid/arready  in/out  1  AR handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid/rready  out/in  1  R handshake

Behaviour:
- Reset, while asserted: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, rdata = 0; both FSMs go to IDLE. Memory contents are not reset.
- awready and arready are registered. They rise the first cycle after reset deasserts, then stay high in IDLE.
- Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)], where ADDR_LSB = log2(DATA_WIDTH/8). Addresses beyond the memory alias modulo MEM_DEPTH.
- Next address: INCR adds 1<<size, modulo 2^ADDR_WIDTH. FIXED holds the address. WRAP is unsupported.
- Error condition, per burst: size > ADDR_LSB or burst = WRAP.
  - Writes: data is accepted and discarded, memory unchanged, bresp = SLVERR.
  - Reads: rdata = 0 with rresp = SLVERR on every beat.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: on awvalid&&awready, latch the descriptor, clear the beat counter and error flag, set awready=0 and wready=1 next cycle.
  - W_DATA: on each wvalid&&wready, write the enabled bytes to mem[index], advance the address, increment the counter.
  - Burst length is governed by awlen only. wlast high on a non-final beat, or low on the final beat, sets the error flag; the burst still runs to awlen+1 beats.
  - After the final beat: wready=0, bvalid=1, bresp registered, go W_RESP.
  - W_RESP: bvalid and bresp hold until bready. Next cycle bvalid=0, awready=1, back to W_IDLE.
  - Minimum write turnaround: AW handshake to bvalid = len+2 cycles with wvalid held high.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: on arvalid&&arready, latch the descriptor and set arready=0. Next cycle: rvalid=1, rdata = mem[start index], rlast = (arlen==0). Latency is 1 cycle.
  - R_DATA: rdata, rresp and rlast hold stable while rvalid && !rready.
  - On rvalid&&rready, non-final beat: advance the address; next cycle rdata = next word and rlast = (counter+1 == arlen).
  - On rvalid&&rready, final beat: rvalid=0, rlast=0, arready=1, back to R_IDLE.
- Read/write collision on the same word in the same cycle: the read samples the old contents (read-before-write).
- Reset mid-burst: the burst is abandoned and no bvalid or rlast is produced. Bytes already written stay written.
- Concurrent AW and AR handshakes in the same cycle are both accepted.

Decomposition:
- Package axi_burst_pkg holds:
  - burst type constants (FIXED/INCR/WRAP)
  - response codes (OKAY/SLVERR)
  - write and read FSM state enums
  - helper function for the word-index width
- One sub-module, axi_burst_addr_gen: combinational next-address logic taking addr, size and burst. It is instantiated once per channel.

Test Plan:
1. INCR write at 0x0, awlen=7, size=010, data 10..17, wstrb=F, wlast on beat 8 -> 8 W handshakes, bresp=00. Then INCR read at 0x0, arlen=7 -> rdata 10..17, rlast only with 17, rresp=00.
2. Write 0xAABBCCDD to 0x4, then a single beat of 0x11223344 with wstrb=0101 -> a read of 0x4 returns 0xAA22CC44.
3. FIXED write at 0x10, awlen=3, data 1,2,3,4 -> a FIXED read at 0x10 with arlen=3 returns 4,4,4,4. mem[5] is unchanged.
4. INCR read of 4 beats with rready toggling 1,0,1,0 -> rdata/rlast stable while stalled, exactly 4 handshakes, arready back high 1 cycle after the last beat.
5. 4-beat write with wlast asserted on beat 2 -> wready stays high for 4 beats and bresp=10. Separately, awsize=011 -> bresp=10 and the memory is unchanged on readback.
6. reset asserted during beat 3 of an 8-beat read -> rvalid=0 and arready=0 while in reset. arready=1 one cycle after release; a new burst completes normally.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared constants, FSM state types and sizing helpers for the AXI burst memory slave.
package axi_burst_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    function automatic int word_idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for one AXI channel: INCR steps by the beat size, anything else holds.
module axi_burst_addr_gen
    import axi_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;

    always_comb begin
        step      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
        next_addr = (burst == BURST_INCR) ? addr + step : addr;
    end

endmodule

// File: rtl/axi_memory_slave_burst.sv
// AXI4 burst slave over a word-addressed memory; write and read channels run independent FSMs.
module axi_memory_slave_burst
    import axi_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W    = word_idx_width(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);

    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
        return (size > MAX_SIZE) || (burst == BURST_WRAP);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, aw_next;
    logic [7:0]            awlen_q, awlen_d, wcnt_q, wcnt_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic                  werr_q, werr_d, wdrop_q, wdrop_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_final, mem_we;
    logic [IDX_W-1:0]      mem_widx;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, ar_next;
    logic [7:0]            arlen_q, arlen_d, rcnt_q, rcnt_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  rerr_q, rerr_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  r_final;
    logic [IDX_W-1:0]      rd_idx;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_aw_gen (
        .addr      (awaddr_q),
        .size      (awsize_q),
        .burst     (awburst_q),
        .next_addr (aw_next)
    );

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_ar_gen (
        .addr      (araddr_q),
        .size      (arsize_q),
        .burst     (arburst_q),
        .next_addr (ar_next)
    );

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        wdrop_d   = wdrop_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        mem_widx  = awaddr_q[ADDR_LSB +: IDX_W];
        w_final   = (wcnt_q == awlen_q);
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    awaddr_d  = awaddr;
                    awlen_d   = awlen;
                    awsize_d  = awsize;
                    awburst_d = awburst;
                    wcnt_d    = 8'd0;
                    wdrop_d   = burst_err(awsize, awburst);
                    werr_d    = wdrop_d;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // An erroneous descriptor still consumes its beats but never touches memory
                    mem_we   = !wdrop_q && !reset;
                    awaddr_d = aw_next;
                    wcnt_d   = wcnt_q + 8'd1;
                    if (wlast != w_final) begin
                        werr_d = 1'b1;
                    end
                    if (w_final) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_idx    = araddr[ADDR_LSB +: IDX_W];
        r_final   = (rcnt_q == arlen_q);
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    araddr_d  = araddr;
                    arlen_d   = arlen;
                    arsize_d  = arsize;
                    arburst_d = arburst;
                    rcnt_d    = 8'd0;
                    rerr_d    = burst_err(arsize, arburst);
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (arlen == 8'd0);
                    rresp_d   = rerr_d ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = rerr_d ? '0 : mem_q[rd_idx];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (r_final) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        // Memory is sampled before this edge's write lands: read-before-write
                        rd_idx   = ar_next[ADDR_LSB +: IDX_W];
                        araddr_d = ar_next;
                        rcnt_d   = rcnt_q + 8'd1;
                        rlast_d  = ((rcnt_q + 8'd1) == arlen_q);
                        rdata_d  = rerr_q ? '0 : mem_q[rd_idx];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        awaddr_q  <= awaddr_d;
        awlen_q   <= awlen_d;
        awsize_q  <= awsize_d;
        awburst_q <= awburst_d;
        wcnt_q    <= wcnt_d;
        werr_q    <= werr_d;
        wdrop_q   <= wdrop_d;
        araddr_q  <= araddr_d;
        arlen_q   <= arlen_d;
        arsize_q  <= arsize_d;
        arburst_q <= arburst_d;
        rcnt_q    <= rcnt_d;
        rerr_q    <= rerr_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule
